uart_cmd_responder: RTL and testbench

Hardware responder for the ASCII command protocol the host speaks over the CPU UART. It consumes received bytes from a `uart` instance, parses `wFPGA,<addr>,<data>\n` and `rFPGA,<addr>\n`, and issues one register-bus transaction per command. It returns read data as decimal ASCII to the UART transmitter. This lets register access work without firmware: it is the device end of the link the host drives.

---
 rtl/uart_cmd_responder_if.sv | 29 ++
 rtl/uart_cmd_responder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_if.sv
// Byte stream and register-bus signals of the UART command responder.
// The master modport is the responder's view (it masters the register bus);
// the slave modport is the environment: UART receiver/transmitter and bus target.
`timescale 1ns/1ps
interface uart_cmd_responder_if #(
    parameter int AddrWidth = 16
);
    logic [7:0]           rx_data_i;
    logic                 rx_valid_i;
    logic [7:0]           tx_data_o;
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    logic                 bus_req_o;
    logic                 bus_we_o;
    logic [AddrWidth-1:0] bus_addr_o;
    logic [31:0]          bus_data_o;
    logic [31:0]          bus_data_i;
    logic                 bus_ack_i;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, bus_data_i, bus_ack_i,
        output tx_data_o, tx_valid_o, bus_req_o, bus_we_o, bus_addr_o, bus_data_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, bus_data_i, bus_ack_i,
        input  tx_data_o, tx_valid_o, bus_req_o, bus_we_o, bus_addr_o, bus_data_o
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// ASCII command responder: parses "wFPGA,<addr>,<data>\n" / "rFPGA,<addr>\n",
// runs one register-bus transaction per command and returns read data as
// decimal ASCII (or "ERR\n") to the UART transmitter.
`timescale 1ns/1ps
module uart_cmd_responder #(
    parameter int AddrWidth     = 16,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    uart_cmd_responder_if.master sys_if,
    output logic                 busy_o,
    output logic                 overrun_o
);
    typedef enum logic [2:0] {S_HDR, S_ADDR, S_DATA, S_DISCARD, S_BUS, S_FMT, S_SEND} state_t;

    localparam logic [35:0] ADDR_MAX     = (36'd1 << AddrWidth) - 36'd1;
    localparam logic [35:0] DATA_MAX     = 36'h0_FFFF_FFFF;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TimeoutCycles - 1);
    localparam logic [7:0]  CH_LF        = 8'h0A;
    localparam logic [7:0]  CH_CR        = 8'h0D;
    localparam logic [7:0]  CH_COMMA     = 8'h2C;

    // Expected header character at positions 1..5 ("FPGA,").
    function automatic logic [7:0] hdr_char(input logic [2:0] idx);
        case (idx)
            3'd1:    return "F";
            3'd2:    return "P";
            3'd3:    return "G";
            3'd4:    return "A";
            default: return CH_COMMA;
        endcase
    endfunction

    // Decimal weights, most significant first.
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'd1000000000;
            4'd1:    return 32'd100000000;
            4'd2:    return 32'd10000000;
            4'd3:    return 32'd1000000;
            4'd4:    return 32'd100000;
            4'd5:    return 32'd10000;
            4'd6:    return 32'd1000;
            4'd7:    return 32'd100;
            4'd8:    return 32'd10;
            default: return 32'd1;
        endcase
    endfunction

    state_t               r_state, w_state;
    logic [2:0]           r_hdr_idx, w_hdr_idx;
    logic                 r_is_write, w_is_write;
    logic [31:0]          r_acc, w_acc;
    logic                 r_has_digit, w_has_digit;
    logic                 r_ovf, w_ovf;
    logic [AddrWidth-1:0] r_addr, w_addr;
    logic [31:0]          r_wdata, w_wdata;
    logic [15:0]          r_timer, w_timer;
    logic [31:0]          r_val, w_val;
    logic [3:0]           r_pow_idx, w_pow_idx;
    logic [3:0]           r_digit, w_digit;
    logic                 r_started, w_started;
    logic [3:0]           r_len, w_len;
    logic [3:0]           r_tx_idx, w_tx_idx;
    logic                 r_overrun, w_overrun;
    logic [7:0]           r_buf [12];

    logic                 w_buf_we, w_buf_nl, w_err_load;
    logic [7:0]           w_buf_byte;

    logic [7:0]           w_rx;
    logic                 w_rx_valid, w_is_digit, w_field_ok;
    logic [35:0]          w_acc_mul, w_limit;
    logic [31:0]          w_pow;

    assign w_rx       = sys_if.rx_data_i;
    assign w_rx_valid = sys_if.rx_valid_i && (sys_if.rx_data_i != CH_CR);
    assign w_is_digit = (w_rx >= "0") && (w_rx <= "9");
    assign w_acc_mul  = {4'd0, r_acc} * 36'd10 + {32'd0, w_rx[3:0]};
    assign w_limit    = (r_state == S_ADDR) ? ADDR_MAX : DATA_MAX;
    assign w_field_ok = r_has_digit && !r_ovf;
    assign w_pow      = pow10(r_pow_idx);

    // Next-state and datapath update for parse, bus, format and send phases.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        w_state     = r_state;
        w_hdr_idx   = (r_state == S_HDR) ? r_hdr_idx : 3'd0;
        w_is_write  = r_is_write;
        w_acc       = r_acc;
        w_has_digit = r_has_digit;
        w_ovf       = r_ovf;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_timer     = r_timer;
        w_val       = r_val;
        w_pow_idx   = r_pow_idx;
        w_digit     = r_digit;
        w_started   = r_started;
        w_len       = r_len;
        w_tx_idx    = r_tx_idx;
        w_overrun   = sys_if.rx_valid_i && (r_state inside {S_BUS, S_FMT, S_SEND});
        w_buf_we    = 1'b0;
        w_buf_nl    = 1'b0;
        w_buf_byte  = 8'h00;
        w_err_load  = 1'b0;
        case (r_state)
            S_HDR: if (w_rx_valid) begin
                if (r_hdr_idx == 3'd0) begin
                    if (w_rx == "w" || w_rx == "r") begin
                        w_is_write = (w_rx == "w");
                        w_hdr_idx  = 3'd1;
                    end else if (w_rx != CH_LF) begin
                        w_state = S_DISCARD;
                    end
                end else if (w_rx == hdr_char(r_hdr_idx)) begin
                    if (r_hdr_idx == 3'd5) begin
                        w_state     = S_ADDR;
                        w_acc       = '0;
                        w_has_digit = 1'b0;
                        w_ovf       = 1'b0;
                    end else begin
                        w_hdr_idx = r_hdr_idx + 3'd1;
                    end
                end else if (w_rx == CH_LF) begin
                    w_err_load = 1'b1;
                end else begin
                    w_state = S_DISCARD;
                end
            end
            S_ADDR, S_DATA: if (w_rx_valid) begin
                if (w_is_digit) begin
                    w_acc       = w_acc_mul[31:0];
                    w_has_digit = 1'b1;
                    if (w_acc_mul > w_limit) w_ovf = 1'b1;
                end else if (w_field_ok && r_state == S_ADDR && r_is_write && w_rx == CH_COMMA) begin
                    w_addr      = r_acc[AddrWidth-1:0];
                    w_state     = S_DATA;
                    w_acc       = '0;
                    w_has_digit = 1'b0;
                end else if (w_field_ok && w_rx == CH_LF && !(r_state == S_ADDR && r_is_write)) begin
                    if (r_state == S_ADDR) w_addr = r_acc[AddrWidth-1:0];
                    else                   w_wdata = r_acc;
                    w_state = S_BUS;
                    w_timer = '0;
                end else if (w_rx == CH_LF) begin
                    w_err_load = 1'b1;
                end else begin
                    w_state = S_DISCARD;
                end
            end
            S_DISCARD: if (w_rx_valid && w_rx == CH_LF) w_err_load = 1'b1;
            S_BUS: begin
                if (sys_if.bus_ack_i) begin
                    if (r_is_write) begin
                        w_state = S_HDR;
                    end else begin
                        w_val     = sys_if.bus_data_i;
                        w_pow_idx = '0;
                        w_digit   = '0;
                        w_started = 1'b0;
                        w_len     = '0;
                        w_state   = S_FMT;
                    end
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_err_load = 1'b1;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            S_FMT: begin
                if (r_val >= w_pow) begin
                    w_val   = r_val - w_pow;
                    w_digit = r_digit + 4'd1;
                end else begin
                    // Leading zeros are skipped; the units digit is always emitted.
                    if (r_digit != 4'd0 || r_started || r_pow_idx == 4'd9) begin
                        w_buf_we   = 1'b1;
                        w_buf_byte = 8'h30 + {4'd0, r_digit};
                        w_len      = r_len + 4'd1;
                        w_started  = 1'b1;
                    end
                    w_digit = '0;
                    if (r_pow_idx == 4'd9) begin
                        w_buf_nl = 1'b1;
                        w_len    = r_len + 4'd2;
                        w_tx_idx = '0;
                        w_state  = S_SEND;
                    end else begin
                        w_pow_idx = r_pow_idx + 4'd1;
                    end
                end
            end
            S_SEND: if (sys_if.tx_ready_i) begin
                if (r_tx_idx == r_len - 4'd1) w_state = S_HDR;
                else                          w_tx_idx = r_tx_idx + 4'd1;
            end
            default: w_state = S_HDR;
        endcase
        if (w_err_load) begin
            w_state  = S_SEND;
            w_len    = 4'd4;
            w_tx_idx = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_HDR;
            r_hdr_idx   <= '0;
            r_is_write  <= 1'b0;
            r_acc       <= '0;
            r_has_digit <= 1'b0;
            r_ovf       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_timer     <= '0;
            r_val       <= '0;
            r_pow_idx   <= '0;
            r_digit     <= '0;
            r_started   <= 1'b0;
            r_len       <= '0;
            r_tx_idx    <= '0;
            r_overrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state;
            r_hdr_idx   <= w_hdr_idx;
            r_is_write  <= w_is_write;
            r_acc       <= w_acc;
            r_has_digit <= w_has_digit;
            r_ovf       <= w_ovf;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_timer     <= w_timer;
            r_val       <= w_val;
            r_pow_idx   <= w_pow_idx;
            r_digit     <= w_digit;
            r_started   <= w_started;
            r_len       <= w_len;
            r_tx_idx    <= w_tx_idx;
            r_overrun   <= w_overrun;
        end
    end

    // Response buffer writes: "ERR\n" preload or formatted digits plus newline.
    always_ff @(posedge clk_i) begin
        // NOTE: the buffer has no reset; every byte is written before SEND reads it.
        if (w_err_load) begin
            r_buf[0] <= "E";
            r_buf[1] <= "R";
            r_buf[2] <= "R";
            r_buf[3] <= CH_LF;
        end else begin
            if (w_buf_we) r_buf[r_len] <= w_buf_byte;
            if (w_buf_nl) r_buf[r_len + 4'd1] <= CH_LF;
        end
    end

    assign sys_if.tx_valid_o = (r_state == S_SEND);
    assign sys_if.tx_data_o  = (r_state == S_SEND) ? r_buf[r_tx_idx] : 8'h00;
    assign sys_if.bus_req_o  = (r_state == S_BUS);
    assign sys_if.bus_we_o   = r_is_write;
    assign sys_if.bus_addr_o = r_addr;
    assign sys_if.bus_data_o = r_wdata;
    assign busy_o            = r_state inside {S_BUS, S_FMT, S_SEND};
    assign overrun_o         = r_overrun;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: table of commands with expected
// bus transactions and TX bytes fed to scoreboards, plus stall, reset and
// overrun sequences.
`timescale 1ns/1ps
module tb_uart_cmd_responder;
    localparam int AW = 16;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    logic busy_o, overrun_o;

    always #5 clk = ~clk;

    uart_cmd_responder_if #(.AddrWidth(AW)) u_if ();

    uart_cmd_responder #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .sys_if    (u_if),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            req_cycles;
    } bus_exp_t;

    typedef struct {
        string         name;
        string         cmd;
        logic [31:0]   rdata;
        int            ack_at;   // request cycle carrying the ack; 0 = never
        string         exp_tx;
        logic          exp_bus;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } vec_t;

    bus_exp_t    bus_q[$];
    logic [7:0]  tx_q[$];
    vec_t        vecs[$];

    int          ack_at = 1;
    logic [31:0] rd_value = '0;
    int          drv_cnt = 0;
    int          ovr_cnt = 0;

    // Bus target: acks on the chosen request cycle, garbage data otherwise.
    always @(posedge clk) begin
        #1;
        if (u_if.bus_req_o) begin
            drv_cnt++;
            u_if.bus_ack_i  = (ack_at != 0) && (drv_cnt == ack_at);
            u_if.bus_data_i = u_if.bus_ack_i ? rd_value : 32'hDEAD_BEEF;
        end else begin
            drv_cnt         = 0;
            u_if.bus_ack_i  = 1'b0;
            u_if.bus_data_i = 32'hDEAD_BEEF;
        end
    end

    logic          in_txn = 1'b0;
    int            mon_cnt = 0;
    bus_exp_t      cur;
    logic          w0;
    logic [AW-1:0] a0;
    logic [31:0]   d0;

    // Bus monitor: compares each transaction to the scoreboard and checks stability/length.
    always @(negedge clk) begin
        if (u_if.bus_req_o) begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                mon_cnt = 1;
                w0 = u_if.bus_we_o; a0 = u_if.bus_addr_o; d0 = u_if.bus_data_o;
                check("bus_req expected", bus_q.size() != 0, 1);
                if (bus_q.size() != 0) begin
                    cur = bus_q.pop_front();
                    check("bus_we", u_if.bus_we_o, cur.we);
                    check("bus_addr", u_if.bus_addr_o, cur.addr);
                    if (cur.we) check("bus_data", u_if.bus_data_o, cur.data);
                end else begin
                    cur.req_cycles = -1;
                end
            end else begin
                mon_cnt++;
                check("bus fields stable", {u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_data_o} == {w0, a0, d0}, 1);
            end
        end else if (in_txn) begin
            in_txn = 1'b0;
            if (cur.req_cycles >= 0) check("bus_req cycles", mon_cnt, cur.req_cycles);
        end
    end

    logic       held = 1'b0;
    logic [7:0] held_data;

    // TX monitor: scoreboard compare on each transfer, stability while stalled.
    always @(negedge clk) begin
        if (u_if.tx_valid_o) begin
            if (held) check("tx_data stable while stalled", u_if.tx_data_o, held_data);
            if (u_if.tx_ready_i) begin
                held = 1'b0;
                check("tx byte expected", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) check("tx byte", u_if.tx_data_o, tx_q.pop_front());
            end else begin
                held = 1'b1;
                held_data = u_if.tx_data_o;
            end
        end else if (held) begin
            held = 1'b0;
            check("tx_valid held while stalled", u_if.tx_valid_o, 1);
        end
    end

    always @(negedge clk) if (overrun_o) ovr_cnt++;

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            u_if.rx_data_i  = s[i];
            u_if.rx_valid_i = 1'b1;
        end
        @(posedge clk); #1;
        u_if.rx_valid_i = 1'b0;
        u_if.rx_data_i  = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_o && !in_txn && tx_q.size() == 0 && bus_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        check({name, " completes"}, done, 1);
        check({name, " busy_o low"}, busy_o, 0);
    endtask

    task automatic expect_tx(input string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    task automatic run_vec(input vec_t v);
        ack_at   = v.ack_at;
        rd_value = v.rdata;
        if (v.exp_bus) bus_q.push_back('{v.we, v.addr, v.wdata, (v.ack_at == 0) ? TO : v.ack_at});
        expect_tx(v.exp_tx);
        send_str(v.cmd);
        wait_idle(v.name);
    endtask

    task automatic wait_tx_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (u_if.tx_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " tx_valid seen"}, seen, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        u_if.rx_data_i  = 8'h00;
        u_if.rx_valid_i = 1'b0;
        u_if.tx_ready_i = 1'b1;
        u_if.bus_ack_i  = 1'b0;
        u_if.bus_data_i = 32'hDEAD_BEEF;

        vecs.push_back('{"write main", "wFPGA,36868,305419896\n", 32'd0, 1, "", 1'b1, 1'b1, 16'h9004, 32'h12345678});
        vecs.push_back('{"read max", "rFPGA,36864\n", 32'hFFFFFFFF, 4, "4294967295\n", 1'b1, 1'b0, 16'h9000, 32'd0});
        vecs.push_back('{"read zero", "rFPGA,36864\n", 32'd0, 1, "0\n", 1'b1, 1'b0, 16'h9000, 32'd0});
        vecs.push_back('{"read inner zeros", "rFPGA,36864\n", 32'd1000000007, 2, "1000000007\n", 1'b1, 1'b0, 16'h9000, 32'd0});
        vecs.push_back('{"bad header", "xFPGA,1\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"addr overflow", "rFPGA,65536\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"data overflow", "wFPGA,1,4294967296\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"empty addr", "rFPGA,\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"timeout", "rFPGA,4\n", 32'd0, 0, "ERR\n", 1'b1, 1'b0, 16'd4, 32'd0});
        vecs.push_back('{"lone newline", "\n", 32'd0, 1, "", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"write limits", "wFPGA,65535,4294967295\n", 32'd0, 3, "", 1'b1, 1'b1, 16'hFFFF, 32'hFFFFFFFF});
        vecs.push_back('{"comma on read", "rFPGA,1,2\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"newline in write addr", "wFPGA,5\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"lowercase header", "rfpga,1\n", 32'd0, 1, "ERR\n", 1'b0, 1'b0, 16'd0, 32'd0});
        vecs.push_back('{"carriage returns", "r\rFPGA,12\r\n", 32'd42, 1, "42\n", 1'b1, 1'b0, 16'd12, 32'd0});
        vecs.push_back('{"read ten", "rFPGA,0\n", 32'd10, 5, "10\n", 1'b1, 1'b0, 16'd0, 32'd0});

        repeat (3) @(posedge clk); #1;
        check("reset tx_valid", u_if.tx_valid_o, 0);
        check("reset tx_data", u_if.tx_data_o, 0);
        check("reset bus_req", u_if.bus_req_o, 0);
        check("reset bus_we", u_if.bus_we_o, 0);
        check("reset bus_addr", u_if.bus_addr_o, 0);
        check("reset bus_data", u_if.bus_data_o, 0);
        check("reset busy", busy_o, 0);
        check("reset overrun", overrun_o, 0);
        reset_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        check("no overrun during table", ovr_cnt, 0);

        // Transmitter stalled for 20 cycles on the third response byte.
        ack_at = 1; rd_value = 32'd123456;
        bus_q.push_back('{1'b0, 16'd7, 32'd0, 1});
        expect_tx("123456\n");
        send_str("rFPGA,7\n");
        wait_tx_valid("stall");
        @(posedge clk); #1;
        @(posedge clk); #1;
        u_if.tx_ready_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("stall tx_valid held", u_if.tx_valid_o, 1);
        check("stall tx_data", u_if.tx_data_o, 8'h33);
        u_if.tx_ready_i = 1'b1;
        wait_idle("stall");

        // Reset pulse in the middle of a response, then a normal write.
        ack_at = 1; rd_value = 32'd987654321;
        bus_q.push_back('{1'b0, 16'd9, 32'd0, 1});
        expect_tx("987654321\n");
        send_str("rFPGA,9\n");
        wait_tx_valid("reset mid send");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        #1;
        check("mid reset tx_valid", u_if.tx_valid_o, 0);
        check("mid reset tx_data", u_if.tx_data_o, 0);
        check("mid reset bus_req", u_if.bus_req_o, 0);
        check("mid reset busy", busy_o, 0);
        check("mid reset bytes sent before reset", tx_q.size(), 8);
        tx_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b1;
        run_vec('{"write after reset", "wFPGA,2,7\n", 32'd0, 1, "", 1'b1, 1'b1, 16'd2, 32'd7});

        // A byte arriving during BUS is dropped with one overrun pulse.
        ovr_cnt = 0;
        ack_at = 10; rd_value = 32'd5;
        bus_q.push_back('{1'b0, 16'd3, 32'd0, 10});
        expect_tx("5\n");
        send_str("rFPGA,3\n");
        send_str("w");
        wait_idle("overrun");
        check("overrun pulses", ovr_cnt, 1);
        run_vec('{"parse after overrun", "rFPGA,11\n", 32'd77, 1, "77\n", 1'b1, 1'b0, 16'd11, 32'd0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
